// File: rtl/qupls_rename_stage_pkg.sv
// Shared types and sizing for the register-rename stage.
package qupls_rename_stage_pkg;

    localparam int NAREG  = 128;
    localparam int NPREG  = 256;
    localparam int AREG_W = $clog2(NAREG);
    localparam int PREG_W = $clog2(NPREG);

    typedef logic [AREG_W-1:0] aregno_t;
    typedef logic [PREG_W-1:0] pregno_t;

    typedef struct packed {
        pregno_t pRa;
        pregno_t pRb;
        pregno_t pRc;
        pregno_t pRt;
        pregno_t old_pRt;
    } rename_out_t;

    // After reset the low NAREG physical registers hold the identity mapping,
    // so only the upper block is available for allocation.
    localparam logic [NPREG-1:0] FREE_INIT = {{(NPREG-NAREG){1'b1}}, {NAREG{1'b0}}};

    function automatic logic [PREG_W:0] popcount(input logic [NPREG-1:0] v);
        logic [PREG_W:0] c;
        c = '0;
        for (int i = 0; i < NPREG; i++) begin
            c = c + {{PREG_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/qupls_rename_stage_ffs.sv
// Find-first-set over the free vector: lowest set bit wins.
// Built as a balanced binary tree, one generate level per index bit.
module qupls_ffs_alloc #(
    parameter  int W  = 256,
    localparam int LW = $clog2(W)
) (
    input  logic [W-1:0]  vec,
    output logic [LW-1:0] idx,
    output logic          found
);

    for (genvar l = 0; l <= LW; l++) begin : g_lvl
        localparam int N = W >> l;
        logic [N-1:0]  f;
        logic [LW-1:0] ix [N];
        if (l == 0) begin : g_leaf
            for (genvar n = 0; n < N; n++) begin : g_n
                assign f[n]  = vec[n];
                assign ix[n] = LW'(n);
            end
        end else begin : g_node
            for (genvar n = 0; n < N; n++) begin : g_n
                assign f[n]  = g_lvl[l-1].f[2*n] | g_lvl[l-1].f[2*n+1];
                assign ix[n] = g_lvl[l-1].f[2*n] ? g_lvl[l-1].ix[2*n] : g_lvl[l-1].ix[2*n+1];
            end
        end
    end

    assign found = g_lvl[LW].f[0];
    assign idx   = g_lvl[LW].ix[0];

endmodule

// File: rtl/qupls_rename_stage.sv
// Single-issue rename stage: speculative/committed RAT plus free vectors,
// one-cycle flush recovery, registered valid/ready output to dispatch.
module qupls_rename_stage
    import qupls_rename_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  aregno_t         in_Ra,
    input  aregno_t         in_Rb,
    input  aregno_t         in_Rc,
    input  aregno_t         in_Rt,
    input  logic            in_has_Rt,
    output logic            out_valid,
    input  logic            out_ready,
    output pregno_t         out_pRa,
    output pregno_t         out_pRb,
    output pregno_t         out_pRc,
    output pregno_t         out_pRt,
    output pregno_t         out_old_pRt,
    input  logic            cmt_valid,
    input  aregno_t         cmt_Rt,
    input  pregno_t         cmt_pRt,
    input  pregno_t         cmt_old_pRt,
    output logic [PREG_W:0] free_cnt
);

    pregno_t          spec_map [NAREG];
    pregno_t          cmt_map  [NAREG];
    logic [NPREG-1:0] spec_free, spec_free_nxt;
    logic [NPREG-1:0] cmt_free, cmt_free_nxt;
    rename_out_t      out_q;
    logic             out_valid_q;
    pregno_t          alloc_idx;
    logic             alloc_found;
    logic             need_alloc, accept, do_alloc;

    qupls_ffs_alloc #(.W(NPREG)) u_ffs (
        .vec   (spec_free),
        .idx   (alloc_idx),
        .found (alloc_found)
    );

    assign need_alloc = in_has_Rt && (in_Rt != '0);
    assign in_ready   = (!out_valid_q || out_ready) && (!need_alloc || alloc_found) && !flush;
    assign accept     = in_valid && in_ready;
    assign do_alloc   = accept && need_alloc;

    // Committed free vector: the new register becomes architectural, the old one is released.
    always_comb begin
        cmt_free_nxt = cmt_free;
        if (cmt_valid) begin
            cmt_free_nxt[cmt_pRt] = 1'b0;
            if (cmt_old_pRt != '0) cmt_free_nxt[cmt_old_pRt] = 1'b1;
        end
    end

    // Speculative free vector: flush restores, else release then allocate (allocate wins).
    always_comb begin
        spec_free_nxt = spec_free;
        if (flush) begin
            spec_free_nxt = cmt_free_nxt;
        end else begin
            if (cmt_valid && cmt_old_pRt != '0) spec_free_nxt[cmt_old_pRt] = 1'b1;
            if (do_alloc) spec_free_nxt[alloc_idx] = 1'b0;
        end
    end

    // Free vector registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_free <= FREE_INIT;
            cmt_free  <= FREE_INIT;
        end else begin
            spec_free <= spec_free_nxt;
            cmt_free  <= cmt_free_nxt;
        end
    end

    // Committed RAT; entry 0 is pinned to p0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NAREG; i++) cmt_map[i] <= pregno_t'(i);
        end else if (cmt_valid && cmt_Rt != '0) begin
            cmt_map[cmt_Rt] <= cmt_pRt;
        end
    end

    // Speculative RAT: flush copies the committed RAT including this cycle's commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NAREG; i++) spec_map[i] <= pregno_t'(i);
        end else if (flush) begin
            for (int i = 0; i < NAREG; i++) spec_map[i] <= cmt_map[i];
            if (cmt_valid && cmt_Rt != '0) spec_map[cmt_Rt] <= cmt_pRt;
        end else if (do_alloc) begin
            spec_map[in_Rt] <= alloc_idx;
        end
    end

    // Output register toward dispatch; holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q   <= 1'b1;
            out_q.pRa     <= spec_map[in_Ra];
            out_q.pRb     <= spec_map[in_Rb];
            out_q.pRc     <= spec_map[in_Rc];
            out_q.pRt     <= need_alloc ? alloc_idx : '0;
            out_q.old_pRt <= need_alloc ? spec_map[in_Rt] : '0;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pRa     = out_q.pRa;
    assign out_pRb     = out_q.pRb;
    assign out_pRc     = out_q.pRc;
    assign out_pRt     = out_q.pRt;
    assign out_old_pRt = out_q.old_pRt;
    assign free_cnt    = popcount(spec_free);

    a_no_p0_alloc: assert property (@(posedge clk) disable iff (!rst_n)
        do_alloc |-> alloc_idx != '0);
    a_old_not_free: assert property (@(posedge clk) disable iff (!rst_n)
        (cmt_valid && cmt_old_pRt != '0) |-> !spec_free[cmt_old_pRt]);
    a_alloc_release_clash: assert property (@(posedge clk) disable iff (!rst_n)
        (do_alloc && cmt_valid) |-> alloc_idx != cmt_old_pRt);
    a_flush_kills_out: assert property (@(posedge clk) disable iff (!rst_n)
        flush |=> !out_valid_q);

endmodule
